decoder_seq: RTL and testbench
==============================

Name: decoder_seq

Overview:
Parametrised, registered successor to the fixed 4-to-16 one-hot decoder. It decodes an SEL_W-bit index into a 2^SEL_W one-hot select with an enable, in one of two modes.
- DIRECT mode tracks IN every cycle.
- SCAN mode autonomously walks the one-hot bit across all outputs with a programmable dwell time, continuous or one-shot.

Used for register-bank / peripheral select and for multiplexed display or bank scanning.

Parameters:
- SEL_W, 4, index width. OUT_W = 2**SEL_W is a derived localparam, not overridable.
- HOLD_W, 8, width of the dwell-count input.

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- EN  in  1  global enable; low forces OUT to 0 (registered)
- MODE  in  1  0 = DIRECT, 1 = SCAN; sampled only in IDLE and DIRECT
- START  in  1  scan start/restart pulse; honoured only when EN=1 and MODE=1, or when already in SCAN
- ONESHOT  in  1  sampled at START; 1 = stop after one full pass
- IN  in  SEL_W  direct index / scan start index
- HOLD  in  HOLD_W  sampled at START; each index is held HOLD+1 cycles
- OUT  out  OUT_W  registered one-hot select, or all-zero
- IDX  out  SEL_W  registered index currently driven (last value held when OUT=0)
- BUSY  out  1  high while in SCAN
- WRAP  out  1  one-cycle pulse, coincident with OUT moving from bit OUT_W-1 to bit 0 by scan advance
- DONE  out  1  one-cycle pulse, coincident with OUT going to 0 at one-shot completion

Behaviour:
- **Reset:** RESET=1 asynchronously forces state=IDLE, OUT=0, IDX=0, BUSY=0, WRAP=0, DONE=0, dwell counter=0, latched hold/oneshot/start=0. Reset mid-scan aborts with no DONE.
- **Registered outputs:** all outputs are registered. A response is visible the cycle after the sampling edge; latency is 1 cycle.
- **WRAP and DONE:** default 0 every cycle; asserted only as stated below.
- **State machine:** states IDLE, DIRECT, SCAN.
- **IDLE:** OUT=0.
  - EN=1, MODE=0 -> DIRECT; at the same edge OUT<=onehot(IN), IDX<=IN.
  - EN=1, MODE=1, START=1 -> SCAN; at the same edge OUT<=onehot(IN), IDX<=IN, start_idx<=IN, hold_r<=HOLD, cnt<=HOLD, oneshot_r<=ONESHOT, BUSY<=1.
  - Otherwise remain in IDLE.
- **DIRECT:** every edge OUT<=onehot(IN), IDX<=IN.
  - EN=0 or MODE=1 -> IDLE with OUT<=0. Entering SCAN from DIRECT requires passing through IDLE plus a START.
- **SCAN:** priority order is EN=0 > START > dwell expiry.
  - EN=0 -> IDLE, OUT<=0, BUSY<=0, no DONE.
  - START=1 -> restart exactly as in the IDLE->SCAN entry, with new IN/HOLD/ONESHOT.
  - cnt>0 -> cnt<=cnt-1.
  - cnt==0 -> advance: nxt=(IDX+1) mod OUT_W.
    - WRAP<=1 if IDX==OUT_W-1.
    - If oneshot_r and nxt==start_idx -> IDLE, OUT<=0, BUSY<=0, DONE<=1.
    - Else OUT<=onehot(nxt), IDX<=nxt, cnt<=hold_r.
  - MODE changes during SCAN are ignored.
- **Dwell count:** HOLD=0 advances every cycle. A one-shot pass holds OUT nonzero for exactly OUT_W*(HOLD+1) cycles.
- **Terminating wrap:** if the terminating advance is also a wrap (start_idx=0), WRAP and DONE both pulse in the same cycle.
- **Output invariant:** OUT is always either all-zero or exactly one-hot. X-free after reset.

Decomposition:
- **Package decoder_pkg:** state enum (IDLE, DIRECT, SCAN) and mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
- **Sub-module onehot_dec:** parametrised combinational SEL_W -> 2^SEL_W decoder, instantiated once to generate onehot(IN) and once to generate onehot(nxt).

Test Plan (SEL_W=4, HOLD_W=8):
1. **Reset:** assert RESET asynchronously mid-scan with OUT=16'h0100 -> OUT=0, IDX=0, BUSY=0 immediately, without waiting for a clock edge; DONE never pulses.
2. **Direct tracking:** EN=1, MODE=0, IN=4'hA -> next cycle OUT=16'h0400, IDX=A. Then IN=3 -> OUT=16'h0008 one cycle later. Then EN=0 -> OUT=16'h0000 next cycle.
3. **Continuous scan:** START, IN=4'hE, HOLD=1, ONESHOT=0 -> OUT=16'h4000 for 2 cycles, 16'h8000 for 2 cycles, then 16'h0001 with WRAP=1 for its first cycle only; scanning continues and BUSY stays 1.
4. **One-shot pass:** START, IN=2, HOLD=0, ONESHOT=1 -> OUT walks 16'h0004 ... 16'h8000, 16'h0001, 16'h0002 over 16 cycles. WRAP pulses once, on the 16'h0001 cycle. Next cycle OUT=0, DONE=1 for 1 cycle, BUSY=0.
5. **Restart and abort:** mid-scan, START with IN=7, HOLD=3 -> OUT=16'h0080 next cycle, held 4 cycles. Then EN=0 -> OUT=0 next cycle, BUSY=0, DONE=0.
6. **Mode ignored during scan:** set MODE=0 while in SCAN -> scan continues unchanged. Then EN=0, EN=1 with MODE=0 -> DIRECT tracking resumes with 1-cycle latency.

Source files
------------

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared types and constants for the decoder_seq block.
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    // Controller states: idle (output dark), direct tracking, autonomous scan
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // MODE input encoding
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_dec
//  Description : Combinational SEL_W -> 2**SEL_W one-hot decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec #(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]      i_sel,
    output logic [(2**SEL_W)-1:0] o_onehot
);

    localparam int OUT_W = 2**SEL_W;

    // One comparator per output bit; exactly one matches any index value
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
            assign o_onehot[gi] = (i_sel == SEL_W'(gi));
        end
    endgenerate

endmodule : onehot_dec
`default_nettype wire

// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_seq
//  Description : Registered one-hot decoder with DIRECT (track IN) and SCAN
//                (auto-walk with programmable dwell, continuous/one-shot)
//                modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W  = 4,
    parameter int HOLD_W = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic                  MODE,
    input  logic                  START,
    input  logic                  ONESHOT,
    input  logic [SEL_W-1:0]      IN,
    input  logic [HOLD_W-1:0]     HOLD,
    output logic [(2**SEL_W)-1:0] OUT,
    output logic [SEL_W-1:0]      IDX,
    output logic                  BUSY,
    output logic                  WRAP,
    output logic                  DONE
);

    localparam int OUT_W = 2**SEL_W;

    // Registered state
    state_t              r_state;
    logic [OUT_W-1:0]    r_out;
    logic [SEL_W-1:0]    r_idx;
    logic                r_busy;
    logic                r_wrap;
    logic                r_done;
    logic [HOLD_W-1:0]   r_cnt;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_oneshot;
    logic [SEL_W-1:0]    r_start_idx;

    // Next-state values
    state_t              w_state_nxt;
    logic [OUT_W-1:0]    w_out_nxt;
    logic [SEL_W-1:0]    w_idx_nxt;
    logic                w_busy_nxt;
    logic                w_wrap_nxt;
    logic                w_done_nxt;
    logic [HOLD_W-1:0]   w_cnt_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic                w_oneshot_nxt;
    logic [SEL_W-1:0]    w_start_idx_nxt;
    logic                w_enter_scan;

    // Decoded views of the direct input and of the scan successor index
    logic [SEL_W-1:0]    w_adv_idx;
    logic [OUT_W-1:0]    w_in_oh;
    logic [OUT_W-1:0]    w_adv_oh;
    logic                w_at_last;

    // Successor wraps naturally because the index is exactly SEL_W bits wide
    assign w_adv_idx = r_idx + SEL_W'(1);
    assign w_at_last = (r_idx == {SEL_W{1'b1}});

    onehot_dec #(.SEL_W(SEL_W)) u_dec_in (
        .i_sel    (IN),
        .o_onehot (w_in_oh)
    );

    onehot_dec #(.SEL_W(SEL_W)) u_dec_adv (
        .i_sel    (w_adv_idx),
        .o_onehot (w_adv_oh)
    );

    // Next-state and next-output computation; hold everything by default,
    // WRAP/DONE are single-cycle pulses so they default low
    always_comb begin
        w_state_nxt     = r_state;
        w_out_nxt       = r_out;
        w_idx_nxt       = r_idx;
        w_busy_nxt      = r_busy;
        w_wrap_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_cnt_nxt       = r_cnt;
        w_hold_nxt      = r_hold;
        w_oneshot_nxt   = r_oneshot;
        w_start_idx_nxt = r_start_idx;
        w_enter_scan    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_out_nxt  = '0;
                w_busy_nxt = 1'b0;
                if (EN && (MODE == MODE_DIRECT)) begin
                    w_state_nxt = ST_DIRECT;
                    w_out_nxt   = w_in_oh;
                    w_idx_nxt   = IN;
                end else if (EN && (MODE == MODE_SCAN) && START) begin
                    w_enter_scan = 1'b1;
                end
            end

            ST_DIRECT: begin
                w_busy_nxt = 1'b0;
                if (!EN || (MODE == MODE_SCAN)) begin
                    // Leaving DIRECT always goes dark; scan needs a START from IDLE
                    w_state_nxt = ST_IDLE;
                    w_out_nxt   = '0;
                end else begin
                    w_out_nxt = w_in_oh;
                    w_idx_nxt = IN;
                end
            end

            ST_SCAN: begin
                // MODE is deliberately not looked at here
                if (!EN) begin
                    w_state_nxt = ST_IDLE;
                    w_out_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end else if (START) begin
                    w_enter_scan = 1'b1;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - HOLD_W'(1);
                end else begin
                    w_wrap_nxt = w_at_last;
                    if (r_oneshot && (w_adv_idx == r_start_idx)) begin
                        // Full pass complete: go dark, IDX keeps last value
                        w_state_nxt = ST_IDLE;
                        w_out_nxt   = '0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_out_nxt = w_adv_oh;
                        w_idx_nxt = w_adv_idx;
                        w_cnt_nxt = r_hold;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_out_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Scan entry and restart share one set of assignments
        if (w_enter_scan) begin
            w_state_nxt     = ST_SCAN;
            w_out_nxt       = w_in_oh;
            w_idx_nxt       = IN;
            w_start_idx_nxt = IN;
            w_hold_nxt      = HOLD;
            w_cnt_nxt       = HOLD;
            w_oneshot_nxt   = ONESHOT;
            w_busy_nxt      = 1'b1;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_out       <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_wrap      <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_oneshot   <= 1'b0;
            r_start_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= w_out_nxt;
            r_idx       <= w_idx_nxt;
            r_busy      <= w_busy_nxt;
            r_wrap      <= w_wrap_nxt;
            r_done      <= w_done_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hold      <= w_hold_nxt;
            r_oneshot   <= w_oneshot_nxt;
            r_start_idx <= w_start_idx_nxt;
        end
    end

    assign OUT  = r_out;
    assign IDX  = r_idx;
    assign BUSY = r_busy;
    assign WRAP = r_wrap;
    assign DONE = r_done;

endmodule : decoder_seq
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_seq
//  Description : Self-checking bench for decoder_seq (SEL_W=4, HOLD_W=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_seq;

    localparam int SEL_W  = 4;
    localparam int HOLD_W = 8;
    localparam int OUT_W  = 16;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              EN, MODE, START, ONESHOT;
    logic [SEL_W-1:0]  IN;
    logic [HOLD_W-1:0] HOLD;
    logic [OUT_W-1:0]  OUT;
    logic [SEL_W-1:0]  IDX;
    logic              BUSY, WRAP, DONE;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: what the selector is doing, in plain integers
    typedef enum int {M_IDLE, M_DIRECT, M_SCAN} mphase_t;
    mphase_t m_phase;
    int      m_idx, m_dwell_left, m_dwell, m_first;
    bit      m_lit, m_single, m_wrap, m_done;

    decoder_seq #(.SEL_W(SEL_W), .HOLD_W(HOLD_W)) u_dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .EN      (EN),
        .MODE    (MODE),
        .START   (START),
        .ONESHOT (ONESHOT),
        .IN      (IN),
        .HOLD    (HOLD),
        .OUT     (OUT),
        .IDX     (IDX),
        .BUSY    (BUSY),
        .WRAP    (WRAP),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = M_IDLE; m_idx = 0; m_dwell_left = 0; m_dwell = 0;
        m_first = 0; m_lit = 0; m_single = 0; m_wrap = 0; m_done = 0;
    endtask

    task automatic model_start();
        m_phase = M_SCAN; m_lit = 1; m_idx = int'(IN); m_first = int'(IN);
        m_dwell = int'(HOLD); m_dwell_left = int'(HOLD); m_single = ONESHOT;
    endtask

    // One clock edge of the reference, using the inputs present at that edge
    task automatic model_step();
        int n;
        m_wrap = 0; m_done = 0;
        if (RESET) begin
            model_reset();
            return;
        end
        case (m_phase)
            M_IDLE: begin
                if (EN && !MODE) begin
                    m_phase = M_DIRECT; m_lit = 1; m_idx = int'(IN);
                end else if (EN && MODE && START) begin
                    model_start();
                end
            end
            M_DIRECT: begin
                if (!EN || MODE) begin
                    m_phase = M_IDLE; m_lit = 0;
                end else begin
                    m_idx = int'(IN);
                end
            end
            default: begin
                if (!EN) begin
                    m_phase = M_IDLE; m_lit = 0;
                end else if (START) begin
                    model_start();
                end else if (m_dwell_left > 0) begin
                    m_dwell_left--;
                end else begin
                    n = (m_idx + 1) % OUT_W;
                    m_wrap = (m_idx == OUT_W - 1);
                    if (m_single && n == m_first) begin
                        m_phase = M_IDLE; m_lit = 0; m_done = 1;
                    end else begin
                        m_idx = n; m_dwell_left = m_dwell;
                    end
                end
            end
        endcase
    endtask

    task automatic compare_all();
        logic [31:0] exp_out;
        exp_out = m_lit ? (32'd1 << m_idx) : 32'd0;
        chk("out",  {16'd0, OUT}, exp_out);
        chk("idx",  {28'd0, IDX}, 32'(m_idx));
        chk("busy", {31'd0, BUSY}, {31'd0, (m_phase == M_SCAN)});
        chk("wrap", {31'd0, WRAP}, {31'd0, m_wrap});
        chk("done", {31'd0, DONE}, {31'd0, m_done});
        chk("onehot0", {31'd0, $onehot0(OUT)}, 32'd1);
    endtask

    // Advance one clock: model follows the edge, outputs compared 1 time unit later
    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic en, input logic mode, input logic st,
                         input logic os, input logic [3:0] in, input logic [7:0] hold);
        EN = en; MODE = mode; START = st; ONESHOT = os; IN = in; HOLD = hold;
    endtask

    initial begin
        int lit_cycles, wraps;
        RESET = 1'b1;
        drive(0, 0, 0, 0, 4'h0, 8'h00);
        model_reset();
        #12;
        compare_all();
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Direct tracking
        drive(1, 0, 0, 0, 4'hA, 8'h00);
        cyc();
        chk("t2_out_a", {16'd0, OUT}, 32'h0400);
        chk("t2_idx_a", {28'd0, IDX}, 32'hA);
        IN = 4'h3;
        cyc();
        chk("t2_out_3", {16'd0, OUT}, 32'h0008);
        EN = 1'b0;
        cyc();
        chk("t2_off", {16'd0, OUT}, 32'h0000);

        // Continuous scan with HOLD=1 crossing the wrap point
        drive(1, 1, 1, 0, 4'hE, 8'd1);
        cyc();
        START = 1'b0;
        chk("t3_e0", {16'd0, OUT}, 32'h4000);
        cyc(); chk("t3_e1", {16'd0, OUT}, 32'h4000);
        cyc(); chk("t3_f0", {16'd0, OUT}, 32'h8000);
        cyc(); chk("t3_f1", {16'd0, OUT}, 32'h8000);
        cyc(); chk("t3_wrap_out", {16'd0, OUT}, 32'h0001);
        chk("t3_wrap", {31'd0, WRAP}, 32'd1);
        cyc(); chk("t3_wrap_gone", {31'd0, WRAP}, 32'd0);
        chk("t3_busy", {31'd0, BUSY}, 32'd1);

        // Mode change ignored while scanning
        MODE = 1'b0;
        repeat (6) cyc();
        chk("t6_still_busy", {31'd0, BUSY}, 32'd1);

        // Restart mid-scan, then abort
        drive(1, 1, 1, 0, 4'h7, 8'd3);
        cyc();
        START = 1'b0;
        chk("t5_restart", {16'd0, OUT}, 32'h0080);
        repeat (3) cyc();
        chk("t5_held", {16'd0, OUT}, 32'h0080);
        EN = 1'b0;
        cyc();
        chk("t5_abort_out", {16'd0, OUT}, 32'h0000);
        chk("t5_abort_busy", {31'd0, BUSY}, 32'd0);
        chk("t5_abort_done", {31'd0, DONE}, 32'd0);

        // Direct resumes after leaving scan
        drive(1, 0, 0, 0, 4'h5, 8'd0);
        cyc();
        chk("t6_direct", {16'd0, OUT}, 32'h0020);
        EN = 1'b0;
        cyc();

        // One-shot pass from index 2, HOLD=0
        drive(1, 1, 1, 1, 4'h2, 8'd0);
        cyc();
        START = 1'b0;
        lit_cycles = (OUT != 0) ? 1 : 0;
        wraps = WRAP ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (OUT != 0) lit_cycles++;
            if (WRAP) begin
                wraps++;
                chk("t4_wrap_at_0001", {16'd0, OUT}, 32'h0001);
            end
        end
        chk("t4_last", {16'd0, OUT}, 32'h0004 >> 1);
        cyc();
        chk("t4_lit_cycles", 32'(lit_cycles), 32'd16);
        chk("t4_wraps", 32'(wraps), 32'd1);
        chk("t4_done", {31'd0, DONE}, 32'd1);
        chk("t4_dark", {16'd0, OUT}, 32'h0000);
        cyc();
        chk("t4_done_pulse", {31'd0, DONE}, 32'd0);

        // One-shot from index 0: terminating advance is also a wrap
        drive(1, 1, 1, 1, 4'h0, 8'd0);
        cyc();
        START = 1'b0;
        repeat (16) cyc();
        chk("tw_wrap", {31'd0, WRAP}, 32'd1);
        chk("tw_done", {31'd0, DONE}, 32'd1);

        // Asynchronous reset mid-scan while OUT=16'h0100
        drive(1, 1, 1, 0, 4'h8, 8'd5);
        cyc();
        START = 1'b0;
        chk("t1_pre", {16'd0, OUT}, 32'h0100);
        #2;
        RESET = 1'b1;
        #1;
        chk("t1_async_out",  {16'd0, OUT}, 32'h0);
        chk("t1_async_idx",  {28'd0, IDX}, 32'h0);
        chk("t1_async_busy", {31'd0, BUSY}, 32'd0);
        model_reset();
        repeat (2) cyc();
        RESET = 1'b0;
        EN = 1'b0;
        cyc();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            EN      = ($urandom % 16) != 0;
            MODE    = ($urandom % 4) != 0;
            START   = ($urandom % 20) == 0;
            ONESHOT = $urandom % 2;
            IN      = 4'($urandom);
            HOLD    = 8'($urandom % 4);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Overall time guard so the run cannot hang
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_decoder_seq
`default_nettype wire
